regbank_reader: RTL and testbench

- Read-side client for the 32 x 32 register bank. On a start command it walks a contiguous, wrapping range of register addresses through one bank read port.
- It captures each word and streams it out on a valid/ready interface, with address and last tags.
- Used for register dumps to the debug/trace path and for context save. It drives sr1 (or sr2) of the bank and consumes the matching rdData.

---
 rtl/regbank_reader.sv | 126 ++++++++++++
 tb/tb_regbank_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_reader.sv
// regbank_reader: read-side client for the register bank.
// On start it walks a contiguous, wrapping address range through one bank
// read port and streams each captured word out on a valid/ready interface.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base, count    dump request; base/count sampled with start
//   abort                 synchronous cancel of the dump in progress
//   rd_addr / rd_data     bank read select (registered) / combinational data
//   out_data, out_addr    captured word and the address it came from
//   out_last              marks the final word of the dump
//   out_valid, out_ready  output handshake
//   busy, done            dump in progress / one-cycle completion pulse
module regbank_reader #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] count,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e        r_state;
  logic [CW-1:0] r_remaining;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_addr;
  logic          r_out_last;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_done;

  // Output slot can take a new word when empty or being drained this edge.
  logic w_slot_free;
  assign w_slot_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_remaining <= '0;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (count != '0) begin
              r_rd_addr   <= base;
              r_remaining <= count;
              r_busy      <= 1'b1;
              r_state     <= StRead;
            end else begin
              // Empty dump: complete immediately without producing beats.
              r_done <= 1'b1;
            end
          end
        end
        StRead: begin
          if (abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= StIdle;
          end else if (w_slot_free) begin
            r_out_data  <= rd_data;
            r_out_addr  <= r_rd_addr;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_remaining == CW'(1));
            r_rd_addr   <= r_rd_addr + AW'(1);  // wraps at bank end
            r_remaining <= r_remaining - CW'(1);
            if (r_remaining == CW'(1)) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= StIdle;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rd_addr   = r_rd_addr;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regbank_reader.sv
// Directed testbench for regbank_reader with a behavioural register bank.
module tb_regbank_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  base = '0;
  logic [5:0]  count = '0;
  logic        abort = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] regfile [32];
  int checks = 0;
  int errors = 0;

  assign rd_data = regfile[rd_addr];

  always #5 clk = ~clk;

  regbank_reader #(.AW(5), .DW(32), .CW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .count     (count),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [4:0] a);
    return 32'(a) * 32'h01010101;
  endfunction

  // Called right after the edge that sampled start. Holds out_ready high and
  // expects n back-to-back beats from address b, then a single done pulse.
  // With junk set, a second start is presented during the dump.
  task automatic collect(input logic [4:0] b, input int n, input bit junk);
    int beats = 0;
    bit seen_done = 1'b0;
    logic [4:0] a;
    out_ready = 1'b1;
    if (junk) begin
      start = 1'b1;
      base  = 5'd20;
      count = 6'd5;
    end
    for (int cyc = 0; cyc < n + 6; cyc++) begin
      tick();
      if (junk && cyc == 0) start = 1'b0;
      if (done) begin
        chk("done_cycle", 32'(cyc), 32'(n));
        chk("beat_count", 32'(beats), 32'(n));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("valid_at_done", 32'(out_valid), 32'd0);
        seen_done = 1'b1;
        break;
      end
      if (out_valid) begin
        a = b + beats[4:0];
        chk("beat_cycle", 32'(cyc), 32'(beats));
        chk("beat_addr", 32'(out_addr), 32'(a));
        chk("beat_data", out_data, model(a));
        chk("beat_last", 32'(out_last), 32'(beats == n - 1));
        chk("beat_busy", 32'(busy), 32'd1);
        beats++;
      end
    end
    chk("done_seen", 32'(seen_done), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = model(5'(i));

    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: base 4, count 3, ready high
    start = 1'b1; base = 5'd4; count = 6'd3;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rd_addr", 32'(rd_addr), 32'd4);
    chk("t1_no_valid_yet", 32'(out_valid), 32'd0);
    collect(5'd4, 3, 1'b0);

    // 2: wrap from 30
    start = 1'b1; base = 5'd30; count = 6'd4;
    tick();
    start = 1'b0;
    collect(5'd30, 4, 1'b0);

    // 3: full bank with ready pattern 1,0,0,1
    start = 1'b1; base = 5'd0; count = 6'd32;
    tick();
    start = 1'b0;
    begin
      int beats = 0;
      bit stalled;
      for (int cyc = 0; cyc < 300 && beats < 32; cyc++) begin
        out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        stalled = out_valid && !out_ready;
        if (out_valid && out_ready) begin
          chk("t3_addr", 32'(out_addr), 32'(beats[4:0]));
          chk("t3_data", out_data, model(beats[4:0]));
          chk("t3_last", 32'(out_last), 32'(beats == 31));
          beats++;
        end
        tick();
        if (stalled) begin
          chk("t3_stall_valid", 32'(out_valid), 32'd1);
          chk("t3_stall_addr", 32'(out_addr), 32'(beats[4:0]));
          chk("t3_stall_data", out_data, model(beats[4:0]));
        end
      end
      chk("t3_beats", 32'(beats), 32'd32);
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      tick();
      chk("t3_done_drop", 32'(done), 32'd0);
    end

    // 4: count 0, then start ignored while busy
    out_ready = 1'b1;
    start = 1'b1; base = 5'd7; count = 6'd0;
    tick();
    start = 1'b0;
    chk("t4_zero_done", 32'(done), 32'd1);
    chk("t4_zero_busy", 32'(busy), 32'd0);
    chk("t4_zero_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t4_zero_done_drop", 32'(done), 32'd0);
    chk("t4_zero_valid2", 32'(out_valid), 32'd0);
    start = 1'b1; base = 5'd10; count = 6'd2;
    tick();
    start = 1'b0;
    collect(5'd10, 2, 1'b1);

    // 5: abort while stalled, then start+abort in idle is honoured
    start = 1'b1; base = 5'd8; count = 6'd8;
    tick();
    start = 1'b0;
    tick();
    chk("t5_beat0", 32'(out_addr), 32'd8);
    tick();
    chk("t5_beat1", 32'(out_addr), 32'd9);
    out_ready = 1'b0;
    tick();
    chk("t5_stall_valid", 32'(out_valid), 32'd1);
    chk("t5_stall_addr", 32'(out_addr), 32'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    chk("t5_abort_done", 32'(done), 32'd1);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_last", 32'(out_last), 32'd0);
    tick();
    chk("t5_done_drop", 32'(done), 32'd0);
    chk("t5_idle_valid", 32'(out_valid), 32'd0);
    start = 1'b1; abort = 1'b1; base = 5'd0; count = 6'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_restart_busy", 32'(busy), 32'd1);
    collect(5'd0, 1, 1'b0);

    // 6: asynchronous reset mid-dump
    start = 1'b1; base = 5'd16; count = 6'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_addr", 32'(out_addr), 32'd17);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_addr", 32'(out_addr), 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_no_done", 32'(done), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    start = 1'b1; base = 5'd3; count = 6'd2;
    tick();
    start = 1'b0;
    collect(5'd3, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
